// File: rtl/apb2axi_pkg.sv
// Shared sizing constants and types for the APB-to-AXI bridge read-data FIFO.
// The geometry is fixed here so the top and the bench size themselves identically.
package apb2axi_pkg;

    localparam int RDF_AXI_DATA_W = 64;
    localparam int RDF_APB_DATA_W = 32;
    localparam int RDF_TAG_W      = 4;
    localparam int RDF_TAG_NUM    = 2 ** RDF_TAG_W;
    localparam int RDF_MAX_BEATS  = 16;
    localparam int RDF_WPB        = RDF_AXI_DATA_W / RDF_APB_DATA_W;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_VALID
    } rdf_rd_state_e;

endpackage

// File: rtl/apb2axi_rdf_mem.sv
// Beat storage for the read-data FIFO: one synchronous write port and one
// asynchronous read port, addressed {tag, beat}.
module apb2axi_rdf_mem #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset; stale contents are unreachable because the
    // per-tag counters that gate every read are reset instead.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apb2axi_rdf.sv
// Read-data FIFO: stores AXI R beats per tag and streams them one APB word per
// request to the register gateway, freeing a tag once its final word is consumed.
module apb2axi_rdf
    import apb2axi_pkg::*;
#(
    parameter int AXI_DATA_W = RDF_AXI_DATA_W,
    parameter int APB_DATA_W = RDF_APB_DATA_W,
    parameter int TAG_W      = RDF_TAG_W,
    parameter int MAX_BEATS  = RDF_MAX_BEATS
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [AXI_DATA_W-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  tag_clr_valid,
    input  logic [TAG_W-1:0]      tag_clr_tag,
    input  logic                  rdf_data_req,
    input  logic [TAG_W-1:0]      rdf_data_req_tag,
    output logic                  rdf_data_valid,
    input  logic                  rdf_data_ready,
    output logic [APB_DATA_W-1:0] rdf_data_out,
    output logic                  rdf_data_last
);

    localparam int WPB     = AXI_DATA_W / APB_DATA_W;
    localparam int TAG_NUM = 2 ** TAG_W;
    localparam int BEAT_AW = $clog2(MAX_BEATS);
    localparam int BCW     = $clog2(MAX_BEATS + 1);
    localparam int WCW     = $clog2(MAX_BEATS * WPB + 1);
    localparam int SEL_W   = (WPB > 1) ? $clog2(WPB) : 1;

    logic [BCW-1:0]     beat_cnt [TAG_NUM];
    logic [WCW-1:0]     rd_word  [TAG_NUM];
    logic [TAG_NUM-1:0] done;

    rdf_rd_state_e    state;
    logic [TAG_W-1:0] rd_tag;

    logic                  wr_fire;
    logic                  clr_wr_same;
    logic [BEAT_AW-1:0]    wr_beat;
    logic [WCW-1:0]        cur_words;
    logic [WCW-1:0]        word_idx;
    logic [BEAT_AW-1:0]    rd_beat;
    logic [SEL_W-1:0]      word_sel;
    logic [AXI_DATA_W-1:0] mem_rdata;
    logic [APB_DATA_W-1:0] beat_words [WPB];
    logic                  word_avail;
    logic                  load_last;
    logic                  clr_hold;
    logic                  consume;
    logic                  free;

    // Write side never looks at the read side; a clear in the same cycle
    // restarts the tag so the accepted beat lands at index 0.
    assign wr_ready    = (beat_cnt[wr_tag] != BCW'(MAX_BEATS));
    assign wr_fire     = wr_valid && wr_ready;
    assign clr_wr_same = tag_clr_valid && (tag_clr_tag == wr_tag);
    assign wr_beat     = clr_wr_same ? '0 : beat_cnt[wr_tag][BEAT_AW-1:0];

    assign cur_words  = WCW'(beat_cnt[rd_tag]) * WCW'(WPB);
    assign word_idx   = rd_word[rd_tag];
    assign rd_beat    = BEAT_AW'(word_idx / WCW'(WPB));
    assign word_sel   = SEL_W'(word_idx % WCW'(WPB));
    assign word_avail = (word_idx < cur_words);
    assign load_last  = done[rd_tag] && ((word_idx + WCW'(1)) == cur_words);

    apb2axi_rdf_mem #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (TAG_W + BEAT_AW)
    ) u_mem (
        .pclk    (pclk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_tag, wr_beat}),
        .wr_data (wr_data),
        .rd_addr ({rd_tag, rd_beat}),
        .rd_data (mem_rdata)
    );

    // NOTE: every iteration assigns its element, so this combinational split
    // cannot infer a latch.
    always_comb begin
        for (int i = 0; i < WPB; i++) begin
            beat_words[i] = mem_rdata[i*APB_DATA_W +: APB_DATA_W];
        end
    end

    // A request always wins; a clear of the held tag abandons the read.
    assign clr_hold = tag_clr_valid && (tag_clr_tag == rd_tag) && (state != R_IDLE);
    assign consume  = (state == R_VALID) && rdf_data_ready && !rdf_data_req && !clr_hold;
    assign free     = consume && rdf_data_last;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // reader in this clock sees the pre-edge value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state          <= R_IDLE;
            rd_tag         <= '0;
            rdf_data_valid <= 1'b0;
            rdf_data_out   <= '0;
            rdf_data_last  <= 1'b0;
        end else if (rdf_data_req) begin
            state          <= R_FETCH;
            rd_tag         <= rdf_data_req_tag;
            rdf_data_valid <= 1'b0;
        end else if (clr_hold) begin
            state          <= R_IDLE;
            rdf_data_valid <= 1'b0;
        end else begin
            case (state)
                R_IDLE: ;
                R_FETCH: begin
                    if (word_avail) begin
                        rdf_data_out   <= beat_words[word_sel];
                        rdf_data_last  <= load_last;
                        rdf_data_valid <= 1'b1;
                        state          <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (rdf_data_ready) begin
                        rdf_data_valid <= 1'b0;
                        state          <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int t = 0; t < TAG_NUM; t++) begin
                beat_cnt[t] <= '0;
                rd_word[t]  <= '0;
            end
            done <= '0;
        end else begin
            for (int t = 0; t < TAG_NUM; t++) begin
                if ((tag_clr_valid && (tag_clr_tag == TAG_W'(t))) ||
                    (free && (rd_tag == TAG_W'(t)))) begin
                    beat_cnt[t] <= (wr_fire && (wr_tag == TAG_W'(t))) ? BCW'(1) : '0;
                    rd_word[t]  <= '0;
                    done[t]     <= wr_fire && (wr_tag == TAG_W'(t)) && wr_last;
                end else begin
                    if (wr_fire && (wr_tag == TAG_W'(t))) begin
                        beat_cnt[t] <= beat_cnt[t] + BCW'(1);
                        if (wr_last) begin
                            done[t] <= 1'b1;
                        end
                    end
                    if (consume && (rd_tag == TAG_W'(t))) begin
                        rd_word[t] <= rd_word[t] + WCW'(1);
                    end
                end
            end
        end
    end

    // A new burst may not target a tag in the same cycle its last word is consumed.
    assert property (@(posedge pclk) disable iff (!presetn)
        !(free && wr_fire && (wr_tag == rd_tag)));

endmodule

// File: tb/tb_apb2axi_rdf.sv
// Bench for apb2axi_rdf: per-tag beat store plus read-request model, compared
// against the DUT on every cycle, with directed scenarios and random traffic.
module tb_apb2axi_rdf;
    import apb2axi_pkg::*;

    localparam int AW  = RDF_AXI_DATA_W;
    localparam int PW  = RDF_APB_DATA_W;
    localparam int TW  = RDF_TAG_W;
    localparam int NT  = 2 ** TW;
    localparam int MB  = RDF_MAX_BEATS;
    localparam int WPB = AW / PW;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [TW-1:0] wr_tag = '0;
    logic [AW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          tag_clr_valid = 1'b0;
    logic [TW-1:0] tag_clr_tag = '0;
    logic          rdf_data_req = 1'b0;
    logic [TW-1:0] rdf_data_req_tag = '0;
    logic          rdf_data_valid;
    logic          rdf_data_ready = 1'b0;
    logic [PW-1:0] rdf_data_out;
    logic          rdf_data_last;

    always #5 pclk = ~pclk;

    apb2axi_rdf dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_tag           (wr_tag),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .tag_clr_valid    (tag_clr_valid),
        .tag_clr_tag      (tag_clr_tag),
        .rdf_data_req     (rdf_data_req),
        .rdf_data_req_tag (rdf_data_req_tag),
        .rdf_data_valid   (rdf_data_valid),
        .rdf_data_ready   (rdf_data_ready),
        .rdf_data_out     (rdf_data_out),
        .rdf_data_last    (rdf_data_last)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored beats, beats written, words consumed, done flag
    // per tag, and the word the gateway is currently being offered.
    logic [AW-1:0] m_mem [NT][MB];
    int            m_bcnt [NT];
    int            m_rw   [NT];
    bit            m_done [NT];
    bit            m_fetching;
    bit            m_valid;
    int            m_tag;
    logic [PW-1:0] m_out;
    bit            m_last;

    function automatic logic [PW-1:0] m_word(input int tag, input int k);
        logic [AW-1:0] b;
        b = m_mem[tag][k / WPB];
        return b[(k % WPB)*PW +: PW];
    endfunction

    task automatic m_reset();
        for (int t = 0; t < NT; t++) begin
            m_bcnt[t] = 0;
            m_rw[t]   = 0;
            m_done[t] = 0;
        end
        m_fetching = 0;
        m_valid    = 0;
        m_tag      = 0;
        m_out      = '0;
        m_last     = 0;
    endtask

    task automatic m_step();
        bit wr_acc, consume, free;
        int k;
        wr_acc  = wr_valid && (m_bcnt[wr_tag] != MB);
        consume = 0;
        free    = 0;
        if (rdf_data_req) begin
            m_fetching = 1;
            m_valid    = 0;
            m_tag      = int'(rdf_data_req_tag);
        end else if (tag_clr_valid && (m_fetching || m_valid) && int'(tag_clr_tag) == m_tag) begin
            m_fetching = 0;
            m_valid    = 0;
        end else if (m_fetching) begin
            if (m_bcnt[m_tag] * WPB > m_rw[m_tag]) begin
                k          = m_rw[m_tag];
                m_out      = m_word(m_tag, k);
                m_last     = m_done[m_tag] && (k + 1 == m_bcnt[m_tag] * WPB);
                m_fetching = 0;
                m_valid    = 1;
            end
        end else if (m_valid && rdf_data_ready) begin
            consume = 1;
            free    = m_last;
            m_valid = 0;
        end
        if (consume) begin
            if (free) begin
                m_bcnt[m_tag] = 0;
                m_rw[m_tag]   = 0;
                m_done[m_tag] = 0;
            end else begin
                m_rw[m_tag]++;
            end
        end
        if (tag_clr_valid) begin
            m_bcnt[tag_clr_tag] = 0;
            m_rw[tag_clr_tag]   = 0;
            m_done[tag_clr_tag] = 0;
        end
        if (wr_acc) begin
            m_mem[wr_tag][m_bcnt[wr_tag]] = wr_data;
            m_bcnt[wr_tag]++;
            if (wr_last) m_done[wr_tag] = 1;
        end
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) m_reset();
        else          m_step();
    end

    always @(negedge pclk) begin
        if (presetn) begin
            check("wr_ready", wr_ready, m_bcnt[wr_tag] != MB);
            check("valid", rdf_data_valid, m_valid);
            if (m_valid && rdf_data_valid) begin
                check("data", rdf_data_out, m_out);
                check("last", rdf_data_last, m_last);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic write_beat(input int tag, input logic [AW-1:0] d, input bit last);
        wr_valid = 1'b1;
        wr_tag   = TW'(tag);
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic send_req(input int tag);
        rdf_data_req     = 1'b1;
        rdf_data_req_tag = TW'(tag);
        tick();
        rdf_data_req = 1'b0;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (rdf_data_valid) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic pop(input int tag, input string name, output logic [PW-1:0] d, output bit last);
        bit ok;
        send_req(tag);
        wait_valid(name, ok);
        d    = rdf_data_out;
        last = rdf_data_last;
        if (ok) begin
            rdf_data_ready = 1'b1;
            tick();
            rdf_data_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] d;
        bit            last, ok;
        logic [AW-1:0] b1 [MB];
        logic [AW-1:0] b2;
        logic [AW-1:0] b7;

        m_reset();
        #3;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_valid", rdf_data_valid, 0);
        check("rst_out", rdf_data_out, 0);
        check("rst_last", rdf_data_last, 0);
        #10 presetn = 1'b1;
        tick();

        // Tag 3: four beats, word k must read back as k * 0x11111111.
        for (int i = 0; i < 4; i++) begin
            write_beat(3, {32'h1111_1111 * (2*i + 1), 32'h1111_1111 * (2*i)}, i == 3);
        end
        for (int k = 0; k < 8; k++) begin
            pop(3, "t3_valid", d, last);
            check("t3_word", d, 32'h1111_1111 * k);
            check("t3_last", last, k == 7);
        end
        check("t3_beat_cnt", dut.beat_cnt[3], 0);
        check("t3_rd_word", dut.rd_word[3], 0);
        check("t3_done", dut.done[3], 0);
        check("t3_model_cnt", m_bcnt[3], 0);

        // Tag 5: request while empty, data arrives five cycles later.
        send_req(5);
        repeat (4) tick();
        write_beat(5, 64'hBBBB_BBBB_AAAA_AAAA, 1'b1);
        @(negedge pclk);
        check("t5_valid_w1", rdf_data_valid, 0);
        @(negedge pclk);
        check("t5_valid_w2", rdf_data_valid, 1);
        check("t5_word0", rdf_data_out, 32'hAAAA_AAAA);
        check("t5_last0", rdf_data_last, 0);
        rdf_data_ready = 1'b1;
        tick();
        rdf_data_ready = 1'b0;
        pop(5, "t5_valid1", d, last);
        check("t5_word1", d, 32'hBBBB_BBBB);
        check("t5_last1", last, 1);

        // Tag 1 full without last; tag 2 still accepts.
        for (int i = 0; i < MB; i++) begin
            b1[i] = {$urandom, $urandom};
            write_beat(1, b1[i], 1'b0);
        end
        wr_valid = 1'b1;
        wr_tag   = 1;
        @(negedge pclk);
        check("t1_full_ready", wr_ready, 0);
        tick();
        b2      = {$urandom, $urandom};
        wr_tag  = 2;
        wr_data = b2;
        @(negedge pclk);
        check("t2_ready", wr_ready, 1);
        tick();
        wr_data = {$urandom, $urandom};
        tick();
        wr_valid = 1'b0;
        pop(1, "t1_valid0", d, last);
        check("t1_word0", d, b1[0][31:0]);
        pop(1, "t1_valid1", d, last);
        check("t1_word1", d, b1[0][63:32]);
        wr_tag = 1;
        @(negedge pclk);
        check("t1_still_full", wr_ready, 0);
        check("t1_beat_cnt", dut.beat_cnt[1], MB);
        check("t1_model_cnt", m_bcnt[1], MB);
        tick();

        // Hold tag 2 word 0, then redirect to tag 7.
        b7 = 64'h7777_0001_7777_0000;
        write_beat(7, b7, 1'b0);
        send_req(2);
        wait_valid("t2_valid", ok);
        check("t2_word0", rdf_data_out, b2[31:0]);
        tick();
        send_req(7);
        @(negedge pclk);
        check("t7_valid_w1", rdf_data_valid, 0);
        check("t2_rd_word", dut.rd_word[2], 0);
        @(negedge pclk);
        check("t7_valid_w2", rdf_data_valid, 1);
        check("t7_word0", rdf_data_out, 32'h7777_0000);
        rdf_data_ready = 1'b1;
        tick();
        rdf_data_ready = 1'b0;

        // Tag 4 cleared while being presented.
        write_beat(4, 64'h4444_4444_4444_4444, 1'b1);
        send_req(4);
        wait_valid("t4_valid", ok);
        tick();
        tag_clr_valid = 1'b1;
        tag_clr_tag   = 4;
        tick();
        tag_clr_valid = 1'b0;
        @(negedge pclk);
        check("t4_valid_drop", rdf_data_valid, 0);
        check("t4_beat_cnt", dut.beat_cnt[4], 0);
        check("t4_model_cnt", m_bcnt[4], 0);
        tick();

        // Reset mid-stream, then the old tag has nothing to give.
        write_beat(6, 64'h6666_6666_6666_6666, 1'b0);
        write_beat(6, 64'h6666_6667_6666_6667, 1'b0);
        send_req(6);
        wait_valid("t6_valid", ok);
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_valid", rdf_data_valid, 0);
        check("mid_rst_out", rdf_data_out, 0);
        check("mid_rst_last", rdf_data_last, 0);
        check("mid_rst_wr_ready", wr_ready, 1);
        @(negedge pclk);
        #2 presetn = 1'b1;
        tick();
        send_req(6);
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            check("t6_stall", rdf_data_valid, 0);
        end
        check("t6_state", dut.state, R_FETCH);
        tick();

        // Random traffic on tags 0..3; no new beats to a tag whose burst is done.
        for (int c = 0; c < 3000; c++) begin
            int t;
            t                = $urandom_range(0, 3);
            wr_tag           = TW'(t);
            wr_valid         = ($urandom_range(0, 2) != 0) && !m_done[t];
            wr_data          = {$urandom, $urandom};
            wr_last          = ($urandom_range(0, 9) == 0);
            rdf_data_req     = ($urandom_range(0, 7) == 0);
            rdf_data_req_tag = TW'($urandom_range(0, 3));
            rdf_data_ready   = $urandom_range(0, 1) != 0;
            tag_clr_valid    = ($urandom_range(0, 49) == 0);
            tag_clr_tag      = TW'($urandom_range(0, 3));
            tick();
        end
        wr_valid       = 1'b0;
        rdf_data_req   = 1'b0;
        rdf_data_ready = 1'b0;
        tag_clr_valid  = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
